// File: rtl/caliptra_prim_gf_pkg.sv
// Shared GF(2^Width) definitions for the multiplier and the inverter.
// Holds the default reduction polynomial and the inverter state type.
package caliptra_prim_gf_pkg;

  // x^32 + x^15 + x^9 + x^7 + x^4 + x^3 + 1, leading term implied.
  localparam logic [31:0] GfIPolyDefault = 32'h0000_8299;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } gf_inv_state_e;

endpackage

// File: rtl/caliptra_prim_gf_mult.sv
// GF(2^Width) multiplier, Horner-style, processing StagesPerCycle bits of operand_b per cycle.
// With StagesPerCycle == Width the product is purely combinational and ack_o follows req_i.
module caliptra_prim_gf_mult
  import caliptra_prim_gf_pkg::*;
#(
  parameter int unsigned      Width          = 32,
  parameter int unsigned      StagesPerCycle = Width,
  parameter logic [Width-1:0] IPoly          = Width'(GfIPolyDefault)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic [Width-1:0] operand_a_i,
  input  logic [Width-1:0] operand_b_i,
  output logic             ack_o,
  output logic [Width-1:0] prod_o
);

  function automatic logic [Width-1:0] gf_xtime(logic [Width-1:0] v);
    return v[Width-1] ? ((v << 1) ^ IPoly) : (v << 1);
  endfunction

  if (StagesPerCycle == Width) begin : gen_comb
    logic             unused_clk_rst;
    logic [Width-1:0] b_win;
    logic [Width-1:0] part;

    assign unused_clk_rst = clk_i ^ rst_ni;

    always_comb begin
      b_win = operand_b_i;
      part  = '0;
      for (int s = 0; s < int'(Width); s++) begin
        part  = gf_xtime(part) ^ (b_win[Width-1] ? operand_a_i : '0);
        b_win = b_win << 1;
      end
    end

    assign prod_o = part;
    assign ack_o  = req_i;

  end else begin : gen_iter
    localparam int unsigned    Loops   = Width / StagesPerCycle;
    localparam int unsigned    CntW    = (Loops > 1) ? $clog2(Loops) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Loops - 1);

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [Width-1:0] part_q, part_d;
    logic [Width-1:0] b_win;

    always_comb begin
      // Window the next StagesPerCycle bits of operand_b into the MSB positions.
      b_win  = operand_b_i << (32'(cnt_q) * StagesPerCycle);
      part_d = (cnt_q == '0) ? '0 : part_q;
      for (int s = 0; s < int'(StagesPerCycle); s++) begin
        part_d = gf_xtime(part_d) ^ (b_win[Width-1] ? operand_a_i : '0);
        b_win  = b_win << 1;
      end
    end

    assign ack_o  = req_i && (cnt_q == LastCnt);
    assign prod_o = part_d;

    always_comb begin
      cnt_d = cnt_q;
      if (req_i) begin
        cnt_d = ack_o ? '0 : cnt_q + CntW'(1);
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q  <= '0;
        part_q <= '0;
      end else if (req_i) begin
        cnt_q  <= cnt_d;
        part_q <= part_d;
      end
    end
  end

endmodule

// File: rtl/caliptra_prim_gf_inv.sv
// Sequential GF(2^Width) inverter: computes a^(2^Width-2) by square-and-accumulate,
// one iteration per cycle, behind an operand-in / result-out valid/ready handshake.
module caliptra_prim_gf_inv
  import caliptra_prim_gf_pkg::*;
#(
  parameter int unsigned      Width = 32,
  parameter logic [Width-1:0] IPoly = Width'(GfIPolyDefault)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] operand_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] inv_o,
  output logic             zero_o,
  output logic             busy_o
);

  localparam int unsigned     CntW    = $clog2(Width);
  localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

  gf_inv_state_e    state_q, state_d;
  logic [Width-1:0] sq_q, sq_d;
  logic [Width-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             zero_q, zero_d;

  logic [Width-1:0] sq_prod;
  logic [Width-1:0] acc_prod;
  logic             ack_sq;
  logic             ack_acc;
  logic             unused_ack;

  assign unused_ack = ack_sq ^ ack_acc;

  caliptra_prim_gf_mult #(
    .Width          (Width),
    .StagesPerCycle (Width),
    .IPoly          (IPoly)
  ) u_mult_sq (
    .clk_i       (clk_i),
    .rst_ni      (1'b1),
    .req_i       (1'b1),
    .operand_a_i (sq_q),
    .operand_b_i (sq_q),
    .ack_o       (ack_sq),
    .prod_o      (sq_prod)
  );

  caliptra_prim_gf_mult #(
    .Width          (Width),
    .StagesPerCycle (Width),
    .IPoly          (IPoly)
  ) u_mult_acc (
    .clk_i       (clk_i),
    .rst_ni      (1'b1),
    .req_i       (1'b1),
    .operand_a_i (acc_q),
    .operand_b_i (sq_q),
    .ack_o       (ack_acc),
    .prod_o      (acc_prod)
  );

  always_comb begin
    state_d = state_q;
    sq_d    = sq_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = BUSY;
          sq_d    = operand_i;
          acc_d   = Width'(1);
          cnt_d   = '0;
          zero_d  = (operand_i == '0);
        end
      end
      BUSY: begin
        sq_d = sq_prod;
        // The first iteration only squares; a^1 is not part of the exponent.
        if (cnt_q != '0) begin
          acc_d = acc_prod;
        end
        if (cnt_q == LastCnt) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sq_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sq_q    <= sq_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q == BUSY);
  assign out_valid_o = (state_q == DONE);
  assign inv_o       = out_valid_o ? acc_q : '0;
  assign zero_o      = out_valid_o & zero_q;

endmodule

// File: tb/tb_caliptra_prim_gf_inv.sv
// Bench for caliptra_prim_gf_inv: an 8-bit AES-field instance for directed cases and the
// default 32-bit instance for random operands, both checked every cycle against a field model.
module tb_caliptra_prim_gf_inv;

  localparam logic [31:0] Poly32 = 32'h0000_8299;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2];
  logic        iv[2];
  logic        ordy[2];
  logic [31:0] opnd[2];

  logic ir8, ov8, zr8, by8;
  logic ir32, ov32, zr32, by32;
  logic [7:0]  inv8;
  logic [31:0] inv32;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] inv_tab[256];

  caliptra_prim_gf_inv #(
    .Width (8),
    .IPoly (8'h1B)
  ) u_dut8 (
    .clk_i       (clk),
    .rst_i       (rst[0]),
    .in_valid_i  (iv[0]),
    .in_ready_o  (ir8),
    .operand_i   (opnd[0][7:0]),
    .out_valid_o (ov8),
    .out_ready_i (ordy[0]),
    .inv_o       (inv8),
    .zero_o      (zr8),
    .busy_o      (by8)
  );

  caliptra_prim_gf_inv u_dut32 (
    .clk_i       (clk),
    .rst_i       (rst[1]),
    .in_valid_i  (iv[1]),
    .in_ready_o  (ir32),
    .operand_i   (opnd[1]),
    .out_valid_o (ov32),
    .out_ready_i (ordy[1]),
    .inv_o       (inv32),
    .zero_o      (zr32),
    .busy_o      (by32)
  );

  // Schoolbook polynomial product followed by long-division reduction.
  function automatic logic [31:0] gf_ref(logic [31:0] a, logic [31:0] b, int w,
                                         logic [31:0] poly);
    logic [63:0] p;
    logic [63:0] full;
    p = '0;
    for (int i = 0; i < w; i++) if (b[i]) p = p ^ (64'(a) << i);
    full = 64'(poly) | (64'd1 << w);
    for (int i = 2 * w - 2; i >= w; i--) if (p[i]) p = p ^ (full << (i - w));
    return p[31:0];
  endfunction

  function automatic logic get_ir(int k);  return (k == 0) ? ir8 : ir32; endfunction
  function automatic logic get_ov(int k);  return (k == 0) ? ov8 : ov32; endfunction
  function automatic logic get_zr(int k);  return (k == 0) ? zr8 : zr32; endfunction
  function automatic logic get_by(int k);  return (k == 0) ? by8 : by32; endfunction
  function automatic logic [31:0] get_inv(int k);
    return (k == 0) ? {24'h0, inv8} : inv32;
  endfunction

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s (w%0d) at %0t: got %h, want %h", name, (k == 0) ? 8 : 32, $time,
                 act, exp);
    end
  endtask

  // Transaction-level model: accept when free, result due Width cycles later, held until taken.
  bit          armed[2];
  bit          inflight[2];
  int          left[2];
  logic [31:0] mop[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        armed[k]    <= 1'b1;
        inflight[k] <= 1'b0;
        left[k]     <= 0;
      end else if (!inflight[k]) begin
        if (iv[k]) begin
          inflight[k] <= 1'b1;
          left[k]     <= (k == 0) ? 8 : 32;
          mop[k]      <= (k == 0) ? (opnd[k] & 32'hFF) : opnd[k];
        end
      end else if (left[k] > 0) begin
        left[k] <= left[k] - 1;
      end else if (ordy[k]) begin
        inflight[k] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (armed[k]) begin
        logic exp_ov;
        exp_ov = inflight[k] && (left[k] == 0);
        chk("in_ready", k, 32'(get_ir(k)), 32'(!inflight[k]));
        chk("busy", k, 32'(get_by(k)), 32'(inflight[k] && (left[k] > 0)));
        chk("out_valid", k, 32'(get_ov(k)), 32'(exp_ov));
        if (!exp_ov) begin
          chk("inv_idle", k, get_inv(k), 32'h0);
          chk("zero_idle", k, 32'(get_zr(k)), 32'h0);
        end else if (mop[k] == '0) begin
          chk("inv_of_zero", k, get_inv(k), 32'h0);
          chk("zero_flag", k, 32'(get_zr(k)), 32'h1);
        end else begin
          chk("zero_flag", k, 32'(get_zr(k)), 32'h0);
          if (k == 0) chk("inv8", k, get_inv(k), 32'(inv_tab[mop[k][7:0]]));
          else        chk("a_times_inv", k, gf_ref(mop[k], get_inv(k), 32, Poly32), 32'h1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int k, input logic [31:0] op);
    int n;
    n = 0;
    while (!get_ir(k) && n < 200) begin
      step();
      n++;
    end
    chk("ready_timeout", k, 32'(get_ir(k)), 32'h1);
    iv[k]   = 1'b1;
    opnd[k] = op;
    step();
    iv[k]   = 1'b0;
    opnd[k] = $urandom;
  endtask

  task automatic collect(input int k, input int hold, input bit pulse,
                         output logic [31:0] res, output logic zero, output int lat);
    lat     = 0;
    ordy[k] = 1'b0;
    while (!get_ov(k) && lat < 200) begin
      step();
      lat++;
    end
    chk("result_timeout", k, 32'(get_ov(k)), 32'h1);
    res  = get_inv(k);
    zero = get_zr(k);
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        iv[k]   = (i % 2 == 0);
        opnd[k] = 32'h77;
      end
      step();
      chk("hold_valid", k, 32'(get_ov(k)), 32'h1);
      chk("hold_inv", k, get_inv(k), res);
    end
    if (pulse) iv[k] = 1'b0;
    ordy[k] = 1'b1;
    step();
    ordy[k] = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    logic        z;
    int          lat;
    logic [31:0] op;

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; iv[k] = 1'b0; ordy[k] = 1'b0; opnd[k] = '0;
    end
    inv_tab[0] = 8'h00;
    for (int a = 1; a < 256; a++)
      for (int b = 1; b < 256; b++)
        if (gf_ref(32'(a), 32'(b), 8, 32'h1B) == 32'h1) inv_tab[a] = 8'(b);

    // Pin the model with hand-known field facts.
    chk("model_inv_53", 0, 32'(inv_tab[8'h53]), 32'hCA);
    chk("model_inv_02", 0, 32'(inv_tab[8'h02]), 32'h8D);
    chk("model_inv_01", 0, 32'(inv_tab[8'h01]), 32'h01);
    chk("model_mul32", 1, gf_ref(32'h2, 32'h8000_414C, 32, Poly32), 32'h1);

    repeat (3) step();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    chk("reset_in_ready", 0, 32'(ir8), 32'h1);
    chk("reset_out_valid", 0, 32'(ov8), 32'h0);
    chk("reset_inv", 1, inv32, 32'h0);

    issue(0, 32'h53);
    collect(0, 0, 1'b0, res, z, lat);
    chk("inv_53", 0, res, 32'hCA);
    chk("latency_53", 0, 32'(lat), 32'd8);

    // Back-to-back: keep in_valid high; the second operand waits for the first result.
    iv[0] = 1'b1; opnd[0] = 32'h01;
    step();
    opnd[0] = 32'h02;
    collect(0, 0, 1'b0, res, z, lat);
    chk("inv_01", 0, res, 32'h01);
    step();
    iv[0] = 1'b0;
    collect(0, 0, 1'b0, res, z, lat);
    chk("inv_02", 0, res, 32'h8D);
    chk("latency_02", 0, 32'(lat), 32'd8);

    issue(0, 32'h00);
    collect(0, 1, 1'b0, res, z, lat);
    chk("inv_00", 0, res, 32'h0);
    chk("zero_00", 0, 32'(z), 32'h1);

    issue(0, 32'h53);
    collect(0, 5, 1'b1, res, z, lat);
    chk("held_inv_53", 0, res, 32'hCA);

    // Abort mid-computation.
    issue(0, 32'h9A);
    repeat (3) step();
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    chk("abort_out_valid", 0, 32'(ov8), 32'h0);
    chk("abort_inv", 0, {24'h0, inv8}, 32'h0);
    chk("abort_in_ready", 0, 32'(ir8), 32'h1);
    issue(0, 32'h53);
    collect(0, 0, 1'b0, res, z, lat);
    chk("post_abort_inv", 0, res, 32'hCA);

    for (int i = 0; i < 40; i++) begin
      issue(0, 32'($urandom_range(0, 255)));
      collect(0, $urandom_range(0, 2), 1'b0, res, z, lat);
    end

    issue(1, 32'h2);
    collect(1, 0, 1'b0, res, z, lat);
    chk("inv32_02", 1, res, 32'h8000_414C);
    chk("latency32", 1, 32'(lat), 32'd32);
    issue(1, 32'h0);
    collect(1, 0, 1'b0, res, z, lat);
    chk("zero32", 1, 32'(z), 32'h1);

    for (int i = 0; i < 1000; i++) begin
      op = $urandom;
      if (op == '0) op = 32'h1;
      issue(1, op);
      collect(1, $urandom_range(0, 2), 1'b0, res, z, lat);
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/caliptra_prim_gf_inv.md
# caliptra_prim_gf_inv

Sequential multiplicative inverter in GF(2^Width) modulo the irreducible polynomial IPoly. It is the inverse-direction companion to the team's GF(2^Width) multiplier: it returns a^-1 so that a·a^-1 = 1. It computes a^(2^Width−2) (Fermat) by repeated squaring and accumulation, and sits beside the multiplier in masking and field-arithmetic datapaths. It uses one operand-in / result-out valid/ready handshake and handles one operation at a time.

## Interface
- Width, 32: field degree; must be ≥ 2.
- IPoly, bits 15,9,7,4,3,0 set: reduction polynomial without the x^Width term. Must match the companion multiplier's default.
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high. One clock; reset is synchronous and active-high.
- in_valid_i  in  1  operand valid.
- in_ready_o  out  1  block can accept an operand (high only in IDLE).
- operand_i  in  Width  element a to invert.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- inv_o  out  Width  a^-1. Zero when out_valid_o is low.
- zero_o  out  1  qualified by out_valid_o; operand was 0, so there is no inverse and inv_o = 0.
- busy_o  out  1  state is BUSY.

## Operation
- States:
  - IDLE: in_ready_o = 1. On in_valid_i, go to BUSY: sq_q ← operand_i, acc_q ← 1, cnt_q ← 0, zero_q ← (operand_i == 0).
  - BUSY: one iteration per cycle.
    - cnt_q == 0: sq_q ← sq_q², acc_q unchanged.
    - cnt_q ≥ 1: acc_q ← acc_q·sq_q and sq_q ← sq_q², both computed from the old sq_q. The two multipliers run in parallel with no chaining.
    - cnt_q increments each cycle. After the iteration with cnt_q == Width−1, go to DONE.
  - DONE: out_valid_o = 1, inv_o = acc_q, zero_o = zero_q. Outputs stay stable while out_ready_i = 0. On out_ready_i, go to IDLE.
- Result: acc = a^(2+4+…+2^(Width−1)) = a^(2^Width−2). For a = 0 this yields 0 naturally; no special datapath case.
- cnt_q width is $clog2(Width). cnt_q never wraps; it is cleared on acceptance.
- in_valid_i outside IDLE is ignored and not accepted. operand_i is sampled only at acceptance, so it may change afterwards.
- Squaring uses a general multiply with both operands equal to sq_q. Reduction is by x·2 steps: shift left, and XOR IPoly when the MSB is set.

## Timing
- Reset values: state IDLE, in_ready_o = 1, out_valid_o = 0, busy_o = 0, inv_o = 0, zero_o = 0, acc_q = 0, sq_q = 0, cnt_q = 0.
- Latency:
  - Acceptance edge E0 enters BUSY.
  - Edges E1…EW perform the iterations for cnt_q = 0…Width−1.
  - out_valid_o is high in the cycle after EW, i.e. Width cycles after E0.
- Minimum period between acceptances is Width+2 cycles: the BUSY cycles, one DONE cycle with out_ready_i high, and one IDLE cycle.
- Simultaneous rst_i with any handshake: reset wins. Reset mid-BUSY or in DONE aborts with no output; the result is lost.
- out_valid_o never drops without out_ready_i, except on reset.

## Structure
- Shared package caliptra_prim_gf_pkg holds:
  - the default IPoly constant, shared with the multiplier;
  - the state typedef gf_inv_state_e {IDLE, BUSY, DONE}.
- Sub-module: two instances of the team's GF multiplier (caliptra_prim_gf_mult) with StagesPerCycle = Width, which is purely combinational.
  - Instance 1 squares (sq_q, sq_q).
  - Instance 2 multiplies (acc_q, sq_q).
  - Their rst_ni is tied to 1'b1 and their clock to clk_i; req_i is tied to 1'b1. Only prod_o is used.
- All registers are in this module.

## Test plan
- Width=8, IPoly=0x1B: operand 0x53 → inv_o=0xCA, zero_o=0, out_valid_o exactly 8 cycles after acceptance.
- Width=8, IPoly=0x1B: operands 0x01 → 0x01 and 0x02 → 0x8D, issued back-to-back. in_ready_o stays low until the first result is taken.
- Operand 0x00 → inv_o=0, zero_o=1.
- Hold out_ready_i=0 for 5 cycles in DONE → inv_o and out_valid_o stay stable. in_valid_i pulses during DONE are not accepted.
- Assert rst_i at cnt_q=3 → next cycle IDLE, out_valid_o=0, inv_o=0, then a fresh operation completes correctly.
- Default Width=32: 1000 random nonzero operands → inverse checked via model product a·inv_o == 1.
